// File: rtl/cpu_core_if.sv
// Instruction-fetch bus between cpu_core (master) and its combinational ROM (slave).
// Zero latency: instr must follow pc within the same cycle. There is no backpressure.
interface cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
);
    logic [PC_W-1:0]   pc;
    logic [DATA_W+4:0] instr;

    modport master (output pc, input instr);
    modport slave  (input pc, output instr);
endinterface

// File: rtl/cpu_core.sv
// Single-issue accumulator CPU: one instruction per enabled edge; en=0 or halted freezes all state.
// Optional return stack with CALL/RET is built only when CPU_CALLRET_EN is defined.
module cpu_core #(
    parameter int DATA_W    = 8,
    parameter int PC_W      = 8,
    parameter int DMEM_AW   = 4,
    parameter int STK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    cpu_core_if.master        romBus,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [3:0]        flags,
    output logic              halted,
    output logic              fault
);
    localparam int M = DATA_W - 1;

    localparam logic [4:0] OP_MOVAB = 5'h01, OP_MOVBA = 5'h02, OP_LDAI = 5'h03, OP_LDBI = 5'h04;
    localparam logic [4:0] OP_ADD   = 5'h05, OP_ADDI  = 5'h06, OP_SUB  = 5'h07, OP_SUBI = 5'h08;
    localparam logic [4:0] OP_AND   = 5'h09, OP_OR    = 5'h0A, OP_XOR  = 5'h0B, OP_NOT  = 5'h0C;
    localparam logic [4:0] OP_SHL   = 5'h0D, OP_SHR   = 5'h0E, OP_LD   = 5'h10, OP_ST   = 5'h11;
    localparam logic [4:0] OP_CMP   = 5'h12, OP_CMPI  = 5'h13, OP_JMP  = 5'h14, OP_JEQ  = 5'h15;
    localparam logic [4:0] OP_JNE   = 5'h16, OP_JCR   = 5'h17, OP_HLT  = 5'h1F;

    if (DATA_W < 4 || DATA_W > 32 || PC_W > DATA_W || DMEM_AW > DATA_W || STK_DEPTH < 1) begin : gBadParams
        $error("cpu_core: invalid parameter combination");
    end

    logic [PC_W-1:0]   pcQ, pcNext, pcInc;
    logic [DATA_W-1:0] regA, regB, aNext, bNext, lit, opnd, aluRes;
    logic [DATA_W:0]   addFull, subFull;
    logic [3:0]        flagsQ, flagsNext;
    logic [4:0]        op;
    logic              haltedQ, haltNext, exec, dmemWe, aluC, aluV, aluUpd;
    logic [DATA_W-1:0] dmem [2**DMEM_AW];

`ifdef CPU_CALLRET_EN
    localparam logic [4:0] OP_CALL = 5'h18, OP_RET = 5'h19;
    localparam int SP_W  = $clog2(STK_DEPTH + 1);
    localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    logic [SP_W-1:0] sp, spNext;
    logic [PC_W-1:0] stk [STK_DEPTH];
    logic            faultQ, faultNext, push;
`endif

    always_comb begin
        op        = romBus.instr[DATA_W+4:DATA_W];
        lit       = romBus.instr[DATA_W-1:0];
        exec      = en && !haltedQ;
        pcInc     = pcQ + PC_W'(1);
        opnd      = (op == OP_ADDI || op == OP_SUBI || op == OP_CMPI) ? lit : regB;
        addFull   = {1'b0, regA} + {1'b0, opnd};
        subFull   = {1'b0, regA} - {1'b0, opnd};
        aNext     = regA;
        bNext     = regB;
        pcNext    = pcInc;
        haltNext  = haltedQ;
        dmemWe    = 1'b0;
        aluRes    = '0;
        aluC      = 1'b0;
        aluV      = 1'b0;
        aluUpd    = 1'b0;
`ifdef CPU_CALLRET_EN
        spNext    = sp;
        faultNext = faultQ;
        push      = 1'b0;
`endif
        case (op)
            OP_MOVAB: aNext = regB;
            OP_MOVBA: bNext = regA;
            OP_LDAI:  aNext = lit;
            OP_LDBI:  bNext = lit;
            OP_ADD, OP_ADDI: begin
                aluRes = addFull[DATA_W-1:0];
                aluC   = addFull[DATA_W];
                aluV   = (regA[M] == opnd[M]) && (aluRes[M] != regA[M]);
                aluUpd = 1'b1;
                aNext  = aluRes;
            end
            // CMP shares the subtractor; only the writeback to A differs
            OP_SUB, OP_SUBI, OP_CMP, OP_CMPI: begin
                aluRes = subFull[DATA_W-1:0];
                aluC   = subFull[DATA_W];
                aluV   = (regA[M] != opnd[M]) && (aluRes[M] != regA[M]);
                aluUpd = 1'b1;
                if (op == OP_SUB || op == OP_SUBI) aNext = aluRes;
            end
            OP_AND: begin aluRes = regA & regB; aluUpd = 1'b1; aNext = aluRes; end
            OP_OR:  begin aluRes = regA | regB; aluUpd = 1'b1; aNext = aluRes; end
            OP_XOR: begin aluRes = regA ^ regB; aluUpd = 1'b1; aNext = aluRes; end
            OP_NOT: begin aluRes = ~regA;       aluUpd = 1'b1; aNext = aluRes; end
            OP_SHL: begin
                aluRes = {regA[DATA_W-2:0], 1'b0};
                aluC   = regA[M];
                aluUpd = 1'b1;
                aNext  = aluRes;
            end
            OP_SHR: begin
                aluRes = {1'b0, regA[DATA_W-1:1]};
                aluC   = regA[0];
                aluUpd = 1'b1;
                aNext  = aluRes;
            end
            OP_LD:  aNext  = dmem[lit[DMEM_AW-1:0]];
            OP_ST:  dmemWe = 1'b1;
            OP_JMP: pcNext = lit[PC_W-1:0];
            OP_JEQ: if (flagsQ[3])  pcNext = lit[PC_W-1:0];
            OP_JNE: if (!flagsQ[3]) pcNext = lit[PC_W-1:0];
            OP_JCR: if (flagsQ[1])  pcNext = lit[PC_W-1:0];
`ifdef CPU_CALLRET_EN
            // Stack errors stop the core in place without touching the stack
            OP_CALL: begin
                if (sp == SP_W'(STK_DEPTH)) begin
                    faultNext = 1'b1;
                    haltNext  = 1'b1;
                    pcNext    = pcQ;
                end else begin
                    push   = 1'b1;
                    spNext = sp + SP_W'(1);
                    pcNext = lit[PC_W-1:0];
                end
            end
            OP_RET: begin
                if (sp == '0) begin
                    faultNext = 1'b1;
                    haltNext  = 1'b1;
                    pcNext    = pcQ;
                end else begin
                    spNext = sp - SP_W'(1);
                    pcNext = stk[IDX_W'(sp - SP_W'(1))];
                end
            end
`endif
            OP_HLT: begin
                haltNext = 1'b1;
                pcNext   = pcQ;
            end
            default: ;
        endcase
        flagsNext = aluUpd ? {aluRes == '0, aluRes[M], aluC, aluV} : flagsQ;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcQ     <= '0;
            regA    <= '0;
            regB    <= '0;
            flagsQ  <= '0;
            haltedQ <= 1'b0;
`ifdef CPU_CALLRET_EN
            sp      <= '0;
            faultQ  <= 1'b0;
`endif
        end else if (exec) begin
            pcQ     <= pcNext;
            regA    <= aNext;
            regB    <= bNext;
            flagsQ  <= flagsNext;
            haltedQ <= haltNext;
`ifdef CPU_CALLRET_EN
            sp      <= spNext;
            faultQ  <= faultNext;
`endif
        end
    end

    // Storage arrays are deliberately not reset
    always_ff @(posedge clk) begin
        if (rst_n && exec && dmemWe) dmem[lit[DMEM_AW-1:0]] <= regA;
    end

`ifdef CPU_CALLRET_EN
    always_ff @(posedge clk) begin
        if (rst_n && exec && push) stk[IDX_W'(sp)] <= pcInc;
    end
    assign fault = faultQ;
`else
    assign fault = 1'b0;
`endif

    assign romBus.pc = pcQ;
    assign reg_a     = regA;
    assign reg_b     = regB;
    assign flags     = flagsQ;
    assign halted    = haltedQ;
endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised single-issue accumulator CPU core, the successor to the fixed 8-bit two-register computer. It fetches one instruction per enabled cycle from an external combinational instruction ROM and executes it in the same cycle. Beyond the previous generation, it adds configurable widths, a status-flag register, conditional jumps, internal data memory, a halt state and an optional hardware return stack. It sits between the board top-level (clock/step source, LEDs) and the instruction memory.

## Interface
- `DATA_W`, 8: register, ALU, literal and data-memory word width (4..32).
- `PC_W`, 8: program counter width; must be ≤ `DATA_W`.
- `DMEM_AW`, 4: data memory address width; depth = 2^`DMEM_AW` words; must be ≤ `DATA_W`.
- `STK_DEPTH`, 4: return-stack entries (used only with `CPU_CALLRET_EN`).
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  execute enable; 0 freezes all state.
- `pc`  out  `PC_W`  instruction address to ROM.
- `instr`  in  `DATA_W+5`  instruction word: [`DATA_W+4`:`DATA_W`] opcode, [`DATA_W-1`:0] literal `lit`.
- `reg_a`  out  `DATA_W`  register A (LED output).
- `reg_b`  out  `DATA_W`  register B.
- `flags`  out  4  {Z,N,C,V}.
- `halted`  out  1  core stopped.
- `fault`  out  1  stack over/underflow (sticky).

## Operation
- Opcodes (hex); all unlisted codes are NOP (PC+1, no other change):
- 00 NOP; 01 A←B; 02 B←A; 03 A←lit; 04 B←lit.
- 05 A←A+B; 06 A←A+lit; 07 A←A−B; 08 A←A−lit; 09 A←A&B; 0A A←A|B; 0B A←A^B; 0C A←~A; 0D A←A<<1; 0E A←A>>1 (logical).
- 10 A←DMEM[lit[`DMEM_AW`-1:0]]; 11 DMEM[lit[`DMEM_AW`-1:0]]←A.
- 12 CMP A,B; 13 CMP A,lit (compute A−x, update flags, discard result).
- 14 JMP; 15 JEQ (Z=1); 16 JNE (Z=0); 17 JCR (C=1). Target = lit[`PC_W`-1:0]; not taken → PC+1.
- 18 CALL; 19 RET (see Configuration). 1F HLT.
- Flags are updated only by 05–0E, 12 and 13; MOV, memory, jump, CALL/RET and HLT hold them.
  - Z = result == 0; N = result MSB.
  - ADD: C = carry-out. SUB/CMP: C = borrow (A < x unsigned).
  - V = signed overflow for ADD/SUB/CMP.
  - Logic ops and NOT: C=0, V=0.
  - SHL: C = old A MSB. SHR: C = old A LSB. Shifts: V=0.
- All arithmetic is modulo 2^`DATA_W`; PC increments modulo 2^`PC_W` (wraps from max to 0).
- HLT: `halted`←1 and PC holds at the HLT address. Only reset clears `halted`. While halted, `en` has no effect.
- Data memory is not reset; reading an unwritten location returns an undefined value.

## Timing
- One instruction per `clk` edge with `en`=1 and `halted`=0; results are visible on outputs the cycle after the edge.
- `instr` is sampled combinationally from `pc` within the same cycle.
- DMEM write (11) and read (10) complete in one cycle. A read at cycle n+1 returns the value written at cycle n.
- `en`=0: PC, A, B, flags, stack, DMEM and `halted` all hold.
- Reset (`rst_n`=0 at an edge) overrides `en` and any in-flight instruction. It sets pc=0, A=0, B=0, flags=0, `halted`=0, `fault`=0 and stack pointer=0; DMEM is untouched.

## Configuration
- `CPU_CALLRET_EN` defined:
  - CALL pushes PC+1 and jumps to lit; RET pops into PC.
  - The stack holds `STK_DEPTH` entries of `PC_W` bits.
  - CALL when full, or RET when empty, sets `fault`=1 and `halted`=1, leaves PC unchanged and does not modify the stack.
- `CPU_CALLRET_EN` undefined:
  - 18 and 19 decode as NOP.
  - No stack storage is built; `fault` is tied to 0.

## Test plan
- Reset/basic: `rst_n`=0 for 2 cycles, then 03 lit=5, 04 lit=3, 05 → A=8, B=3, flags=0000, pc=3.
- Flags/wrap (`DATA_W`=8): A=0x7F, 06 lit=1 → A=0x80, N=1, V=1, C=0. Then 06 lit=0x80 → A=0x00, Z=1, C=1, V=1.
- Branching: A=4, 13 lit=4, 15 lit=0x20 → pc=0x20. Then 13 lit=5, 16 lit=0x40 → pc=0x40 with C=1 (borrow).
- Memory/enable: 03 lit=0xAA, 11 lit=0x3, 03 lit=0, 10 lit=0x3 → A=0xAA. Holding `en`=0 for 5 cycles mid-sequence leaves all outputs unchanged.
- Halt/reset-mid-run: 1F at pc=7 → `halted`=1 and pc stays 7 for 10 cycles despite `en`=1. Asserting `rst_n`=0 → pc=0, `halted`=0 the next cycle.
- With `CPU_CALLRET_EN`, `STK_DEPTH`=2: CALL 0x10, CALL 0x20, RET → pc=0x11. RET → pc=1. A further RET → `fault`=1, `halted`=1, pc=1. Three nested CALLs → `fault` on the third, with pc held at that CALL.
